// File: rtl/crt_timing_pkg.sv
// crt_timing_pkg
//   Shared raster timing constants for the CRT sync generator and the renderer.
//   Holds the default 640x480@60 porch/sync numbers, the derived line/frame
//   totals and the coordinate width used by every raster counter.
package crt_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int axis_total(int visible, int front, int sync, int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/crt_axis_timing.sv
// crt_axis_timing
//   One raster axis (horizontal or vertical): a wrapping position counter plus
//   combinational decode of the sync and visible windows.
// Ports
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   advance_i      step the counter by one position this cycle
//   count_o        current position, 0..TOTAL-1
//   wrap_o         advance_i while at the last position (counter returns to 0)
//   sync_active_o  position lies in the sync window (polarity-neutral)
//   visible_o      position lies in the visible window
module crt_axis_timing
  import crt_timing_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               advance_i,
  output logic [COORD_W-1:0] count_o,
  output logic               wrap_o,
  output logic               sync_active_o,
  output logic               visible_o
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

  if (TOTAL > COORD_MAX) begin : g_total_too_big
    $error("crt_axis_timing: axis total %0d exceeds counter range %0d", TOTAL, COORD_MAX);
  end

  localparam logic [COORD_W-1:0] LAST_C       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] VIS_END_C    = COORD_W'(VISIBLE);
  localparam logic [COORD_W-1:0] SYNC_FIRST_C = COORD_W'(VISIBLE + FRONT);
  localparam logic [COORD_W-1:0] SYNC_LAST_C  = COORD_W'(VISIBLE + FRONT + SYNC - 1);

  logic [COORD_W-1:0] count_q;
  logic [COORD_W-1:0] count_d;
  logic               at_last;

  assign at_last = (count_q == LAST_C);

  always_comb begin
    count_d = count_q;
    if (advance_i) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o       = count_q;
  assign wrap_o        = advance_i & at_last;
  assign sync_active_o = (count_q >= SYNC_FIRST_C) && (count_q <= SYNC_LAST_C);
  assign visible_o     = (count_q < VIS_END_C);

endmodule

// File: rtl/crt_sync_generator.sv
// crt_sync_generator
//   Raster timing stage running on CLK only. CRTclock is sampled as a level and
//   its rising edge becomes a one-CLK pixel enable that steps the H/V counters.
//   All outputs come from a single register layer and lag the counters by one CLK.
// Ports
//   CLK         system clock
//   RESET       asynchronous active-high reset
//   CRTclock    divided pixel clock, used as a level
//   hSync       horizontal sync (polarity per SYNC_LOW), registered
//   vSync       vertical sync (polarity per SYNC_LOW), registered
//   videoOn     inside the visible area, registered
//   pixelX      horizontal position, registered
//   pixelY      vertical position, registered
//   frameStart  one-CLK pulse when the raster enters (0,0)
module crt_sync_generator
  import crt_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_LOW  = 1'b1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CRTclock,
  output logic               hSync,
  output logic               vSync,
  output logic               videoOn,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               frameStart
);

  logic               crt_prev_q;
  logic               pixel_en;
  logic               frame_wrap_q;

  logic [COORD_W-1:0] h_count;
  logic               h_wrap;
  logic               h_sync_act;
  logic               h_visible;
  logic [COORD_W-1:0] v_count;
  logic               v_wrap;
  logic               v_sync_act;
  logic               v_visible;

  logic               hsync_q;
  logic               vsync_q;
  logic               video_on_q;
  logic [COORD_W-1:0] pixel_x_q;
  logic [COORD_W-1:0] pixel_y_q;
  logic               frame_start_q;

  // Previous level is cleared by reset, so a CRTclock already high at release
  // counts as a rising edge on the first CLK.
  assign pixel_en = CRTclock & ~crt_prev_q;

  crt_axis_timing #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk_i         (CLK),
    .rst_i         (RESET),
    .advance_i     (pixel_en),
    .count_o       (h_count),
    .wrap_o        (h_wrap),
    .sync_active_o (h_sync_act),
    .visible_o     (h_visible)
  );

  // h_wrap already includes pixel_en, so the line count steps on the same
  // edge the pixel count returns to zero.
  crt_axis_timing #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk_i         (CLK),
    .rst_i         (RESET),
    .advance_i     (h_wrap),
    .count_o       (v_count),
    .wrap_o        (v_wrap),
    .sync_active_o (v_sync_act),
    .visible_o     (v_visible)
  );

  // frame_wrap_q marks the one cycle in which the counters sit freshly at (0,0);
  // sitting at (0,0) out of reset or during a stall does not re-trigger it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      crt_prev_q   <= 1'b0;
      frame_wrap_q <= 1'b0;
    end else begin
      crt_prev_q   <= CRTclock;
      frame_wrap_q <= v_wrap;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hsync_q       <= SYNC_LOW;
      vsync_q       <= SYNC_LOW;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= h_sync_act ^ SYNC_LOW;
      vsync_q       <= v_sync_act ^ SYNC_LOW;
      video_on_q    <= h_visible & v_visible;
      pixel_x_q     <= h_count;
      pixel_y_q     <= v_count;
      frame_start_q <= frame_wrap_q;
    end
  end

  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign videoOn    = video_on_q;
  assign pixelX     = pixel_x_q;
  assign pixelY     = pixel_y_q;
  assign frameStart = frame_start_q;

endmodule

// File: tb/tb_crt_sync_generator.sv
// tb_crt_sync_generator
//   Randomised bench for crt_sync_generator using a reduced raster so that
//   several whole frames fit in a short run. The reference model keeps a single
//   linear tick count since reset and derives position, windows and frame
//   starts from it arithmetically.
module tb_crt_sync_generator;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CRTclock;
  logic       hSync, vSync, videoOn, frameStart;
  logic [9:0] pixelX, pixelY;

  crt_sync_generator #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SYNC_LOW  (1'b1)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CRTclock   (CRTclock),
    .hSync      (hSync),
    .vSync      (vSync),
    .videoOn    (videoOn),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .frameStart (frameStart)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state
  int m_n;
  bit m_prev;
  bit m_wrap;
  int e_x, e_y;
  bit e_hs, e_vs, e_vo, e_fs;
  int fs_dut_cnt = 0;
  int fs_exp_cnt = 0;

  task automatic model_reset();
    m_n    = 0;
    m_prev = 1'b0;
    m_wrap = 1'b0;
    e_x = 0; e_y = 0;
    e_hs = 1'b1; e_vs = 1'b1; e_vo = 1'b0; e_fs = 1'b0;
  endtask

  // Outputs after an edge reflect the position held before it.
  task automatic model_step(input bit crt);
    int  h, v;
    bit  tick;
    h = m_n % HT;
    v = m_n / HT;
    e_x  = h;
    e_y  = v;
    e_vo = (h < HV) && (v < VV);
    e_hs = !((h >= HV + HF) && (h < HV + HF + HS));
    e_vs = !((v >= VV + VF) && (v < VV + VF + VS));
    e_fs = m_wrap;
    tick = crt && !m_prev;
    m_wrap = tick && (m_n == FT - 1);
    if (tick) m_n = (m_n + 1) % FT;
    m_prev = crt;
  endtask

  task automatic compare_all();
    check_val("pixelX", 32'(pixelX), 32'(e_x));
    check_val("pixelY", 32'(pixelY), 32'(e_y));
    check_val("hSync", 32'(hSync), 32'(e_hs));
    check_val("vSync", 32'(vSync), 32'(e_vs));
    check_val("videoOn", 32'(videoOn), 32'(e_vo));
    check_val("frameStart", 32'(frameStart), 32'(e_fs));
  endtask

  int phase = 0;
  int rst_hold = 0;

  // mode 0: regular 4-CLK pixel clock, 1: random level, 2: stuck high, 3: stuck low
  task automatic cycle(input int mode, input bit async_rst);
    @(negedge CLK);
    case (mode)
      0: begin phase++; CRTclock = ((phase % 4) >= 2); end
      1: CRTclock = 1'($urandom_range(0, 1));
      2: CRTclock = 1'b1;
      default: CRTclock = 1'b0;
    endcase
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) RESET = 1'b0;
    end
    @(posedge CLK);
    if (RESET) model_reset();
    else model_step(CRTclock);
    #1;
    compare_all();
    if (frameStart) fs_dut_cnt++;
    if (e_fs) fs_exp_cnt++;
    if (async_rst) begin
      #2;
      RESET = 1'b1;
      model_reset();
      #1;
      compare_all();
      rst_hold = 2;
    end
  endtask

  task automatic run(input int mode, input int n);
    for (int i = 0; i < n; i++) cycle(mode, 1'b0);
  endtask

  // Free-run regular pixel clock until the model reaches a raster position.
  task automatic run_until_pos(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (m_n != target && k < budget) begin
      cycle(0, 1'b0);
      k++;
    end
    check_val(tag, 32'(m_n == target), 32'd1);
  endtask

  initial begin
    RESET    = 1'b0;
    CRTclock = 1'b0;
    #1;
    RESET = 1'b1;
    model_reset();
    #1;
    compare_all();
    rst_hold = 2;

    run(0, 2);
    run(0, 2 * FT * 4 + 200);
    run(1, 1500);

    // stall mid-line in both directions, then resume
    run_until_pos(3 * HT + 12, FT * 4 + 100, "reach_stall_pos");
    run(2, 100);
    run(3, 50);
    run(0, 100);

    // random pixel clock again, then mid-frame asynchronous reset
    run(1, 800);
    run_until_pos(8 * HT + 5, FT * 4 + 100, "reach_reset_pos");
    cycle(0, 1'b1);
    run(0, FT * 4 + 300);

    check_val("frame_count", 32'(fs_dut_cnt), 32'(fs_exp_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
